// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_bus_arbiter_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    // Grant identifiers
    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

    // Byte enables driven on fetches and loads
    localparam logic [3:0] SEL_NONE = 4'b0000;

endpackage

// File: rtl/mem_arb_prio.sv
// Priority select between fetch and data requesters, with a run counter that
// forces a fetch grant once data has won MAX_DATA_RUN times in a row while
// fetch was waiting.
module mem_arb_prio
    import mem_bus_arbiter_pkg::*;
#(
    parameter int MAX_DATA_RUN = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inst_req,
    input  logic i_data_req,
    input  logic i_gnt_valid,
    output logic o_gnt_id
);

    localparam int CNT_W = $clog2(MAX_DATA_RUN + 1);
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_DATA_RUN);

    logic [CNT_W-1:0] r_run_cnt;
    logic             w_starved;

    // Data wins by default; fetch wins when it has waited out a full data run.
    always_comb begin
        w_starved = (r_run_cnt == RUN_MAX);
        o_gnt_id  = GNT_INST;
        if (i_data_req && !(i_inst_req && w_starved)) begin
            o_gnt_id = GNT_DATA;
        end
    end

    // Count data grants made while fetch is waiting; any other grant clears the run.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_run_cnt <= '0;
        end else if (i_gnt_valid) begin
            if ((o_gnt_id == GNT_DATA) && i_inst_req) begin
                if (!w_starved) begin
                    r_run_cnt <= r_run_cnt + 1'b1;
                end
            end else begin
                r_run_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like memory port between the fetch and load/store requesters.
// One transaction in flight at a time; completion is signalled by a one-cycle
// ok pulse on the winning side.
//
// state   | meaning
// IDLE    | no transaction; pick a winner when any request is high
// ADDR    | mem_req asserted with a stable payload, waiting for mem_addr_ok
// DATA    | command accepted, waiting for mem_data_ok
// RESP    | winner's ok pulses for one cycle, then back to IDLE
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_inst_req,
    input  logic [ADDR_W-1:0] i_inst_addr,
    output logic [DATA_W-1:0] o_inst_rdata,
    output logic              o_inst_ok,
    input  logic              i_data_req,
    input  logic              i_data_wr,
    input  logic [3:0]        i_data_sel,
    input  logic [ADDR_W-1:0] i_data_addr,
    input  logic [DATA_W-1:0] i_data_wdata,
    output logic [DATA_W-1:0] o_data_rdata,
    output logic              o_data_ok,
    output logic              o_mem_req,
    output logic              o_mem_wr,
    output logic [3:0]        o_mem_sel,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_addr_ok,
    input  logic              i_mem_data_ok,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_stall
);

    arb_state_t        r_state,      w_state_nxt;
    logic              r_gnt,        w_gnt_nxt;
    logic              r_mem_req,    w_mem_req_nxt;
    logic              r_mem_wr,     w_mem_wr_nxt;
    logic [3:0]        r_mem_sel,    w_mem_sel_nxt;
    logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata,  w_mem_wdata_nxt;
    logic [DATA_W-1:0] r_inst_rdata, w_inst_rdata_nxt;
    logic [DATA_W-1:0] r_data_rdata, w_data_rdata_nxt;
    logic              r_inst_ok,    w_inst_ok_nxt;
    logic              r_data_ok,    w_data_ok_nxt;

    logic              w_gnt_valid;
    logic              w_gnt_id;
    logic              w_complete;

    assign w_gnt_valid = (r_state == ST_IDLE) && (i_inst_req || i_data_req);

    mem_arb_prio #(
        .MAX_DATA_RUN (MAX_DATA_RUN)
    ) u_prio (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_inst_req  (i_inst_req),
        .i_data_req  (i_data_req),
        .i_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );

    // Next-state and next-register values for the transaction sequencer.
    always_comb begin
        w_state_nxt      = r_state;
        w_gnt_nxt        = r_gnt;
        w_mem_req_nxt    = r_mem_req;
        w_mem_wr_nxt     = r_mem_wr;
        w_mem_sel_nxt    = r_mem_sel;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_inst_rdata_nxt = r_inst_rdata;
        w_data_rdata_nxt = r_data_rdata;
        w_inst_ok_nxt    = 1'b0;
        w_data_ok_nxt    = 1'b0;
        w_complete       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_gnt_nxt     = w_gnt_id;
                    w_mem_req_nxt = 1'b1;
                    w_state_nxt   = ST_ADDR;
                    if (w_gnt_id == GNT_DATA) begin
                        w_mem_wr_nxt    = i_data_wr;
                        w_mem_sel_nxt   = i_data_wr ? i_data_sel : SEL_NONE;
                        w_mem_addr_nxt  = i_data_addr;
                        w_mem_wdata_nxt = i_data_wr ? i_data_wdata : '0;
                    end else begin
                        w_mem_wr_nxt    = 1'b0;
                        w_mem_sel_nxt   = SEL_NONE;
                        w_mem_addr_nxt  = i_inst_addr;
                        w_mem_wdata_nxt = '0;
                    end
                end
            end
            ST_ADDR: begin
                if (i_mem_addr_ok) begin
                    w_mem_req_nxt = 1'b0;
                    if (i_mem_data_ok) begin
                        w_complete  = 1'b1;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (i_mem_data_ok) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A store completion carries no read data, so data_rdata keeps its old word.
        if (w_complete) begin
            if (r_gnt == GNT_INST) begin
                w_inst_rdata_nxt = i_mem_rdata;
                w_inst_ok_nxt    = 1'b1;
            end else begin
                if (!r_mem_wr) begin
                    w_data_rdata_nxt = i_mem_rdata;
                end
                w_data_ok_nxt = 1'b1;
            end
        end
    end

    // State and payload registers; reset abandons any transaction in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_gnt        <= GNT_INST;
            r_mem_req    <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_sel    <= SEL_NONE;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
            r_inst_ok    <= 1'b0;
            r_data_ok    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_gnt        <= w_gnt_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_wr     <= w_mem_wr_nxt;
            r_mem_sel    <= w_mem_sel_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_inst_rdata <= w_inst_rdata_nxt;
            r_data_rdata <= w_data_rdata_nxt;
            r_inst_ok    <= w_inst_ok_nxt;
            r_data_ok    <= w_data_ok_nxt;
        end
    end

    assign o_mem_req    = r_mem_req;
    assign o_mem_wr     = r_mem_wr;
    assign o_mem_sel    = r_mem_sel;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_inst_rdata = r_inst_rdata;
    assign o_data_rdata = r_data_rdata;
    assign o_inst_ok    = r_inst_ok;
    assign o_data_ok    = r_data_ok;

    // A side stops stalling the pipeline in the cycle its ok pulses.
    assign o_stall = (i_inst_req & ~r_inst_ok) | (i_data_req & ~r_data_ok);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: memory handshakes are driven by hand and
// every expected value is written out in the stimulus.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ok;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_sel;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ok;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        stall;

    int n_total = 0;
    int n_bad   = 0;
    int cyc_cnt = 0;

    mem_bus_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .MAX_DATA_RUN (4)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_inst_req    (inst_req),
        .i_inst_addr   (inst_addr),
        .o_inst_rdata  (inst_rdata),
        .o_inst_ok     (inst_ok),
        .i_data_req    (data_req),
        .i_data_wr     (data_wr),
        .i_data_sel    (data_sel),
        .i_data_addr   (data_addr),
        .i_data_wdata  (data_wdata),
        .o_data_rdata  (data_rdata),
        .o_data_ok     (data_ok),
        .o_mem_req     (mem_req),
        .o_mem_wr      (mem_wr),
        .o_mem_sel     (mem_sel),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .i_mem_addr_ok (mem_addr_ok),
        .i_mem_data_ok (mem_data_ok),
        .i_mem_rdata   (mem_rdata),
        .o_stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requests must be held until their ok; dropping one early is a protocol error.
    logic inst_wait, data_wait;
    always @(posedge clk) begin
        if (rst) begin
            inst_wait <= 1'b0;
            data_wait <= 1'b0;
        end else begin
            assert (!(inst_wait && !inst_req && !inst_ok))
                else $error("inst_req dropped before inst_ok");
            assert (!(data_wait && !data_req && !data_ok))
                else $error("data_req dropped before data_ok");
            inst_wait <= inst_req && !inst_ok;
            data_wait <= data_req && !data_ok;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for a grant, checks the payload, plays the memory side and
    // leaves the caller in the ok cycle. lat counts edges from grant to ok sample.
    task automatic do_xact(input string tag, input logic exp_side,
                           input logic [31:0] exp_addr, input logic exp_wr,
                           input logic [3:0] exp_sel, input logic [31:0] exp_wdata,
                           input int addr_wait, input bit same,
                           input logic [31:0] rd, output int lat);
        int n;
        int g;
        n   = 0;
        lat = 0;
        while (!mem_req && n < 8) begin
            cyc();
            n++;
        end
        chk_eq({tag, ":grant"}, {31'd0, mem_req}, 32'd1);
        if (!mem_req) return;
        g = cyc_cnt;
        chk_eq({tag, ":addr"}, mem_addr, exp_addr);
        chk_eq({tag, ":wr"}, {31'd0, mem_wr}, {31'd0, exp_wr});
        chk_eq({tag, ":sel"}, {28'd0, mem_sel}, {28'd0, exp_sel});
        if (exp_wr) chk_eq({tag, ":wdata"}, mem_wdata, exp_wdata);
        for (int i = 0; i < addr_wait; i++) begin
            cyc();
            chk_eq({tag, ":req_held"}, {31'd0, mem_req}, 32'd1);
            chk_eq({tag, ":addr_held"}, mem_addr, exp_addr);
            if (exp_wr) chk_eq({tag, ":wdata_held"}, mem_wdata, exp_wdata);
        end
        mem_addr_ok = 1'b1;
        mem_data_ok = same;
        mem_rdata   = rd;
        cyc();
        mem_addr_ok = 1'b0;
        if (!same) begin
            chk_eq({tag, ":req_low"}, {31'd0, mem_req}, 32'd0);
            mem_data_ok = 1'b1;
            cyc();
        end
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
        lat = cyc_cnt - g + 1;
        chk_eq({tag, ":inst_ok"}, {31'd0, inst_ok}, {31'd0, exp_side == 1'b0});
        chk_eq({tag, ":data_ok"}, {31'd0, data_ok}, {31'd0, exp_side == 1'b1});
        if (exp_side == 1'b0) chk_eq({tag, ":inst_rdata"}, inst_rdata, rd);
        else if (!exp_wr)     chk_eq({tag, ":data_rdata"}, data_rdata, rd);
    endtask

    initial begin
        int lat;
        int dcnt;
        logic        exp_sides [6];
        logic [31:0] exp_a;

        rst = 1'b1;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_sel = '0; data_addr = '0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        cyc();
        cyc();
        chk_eq("rst:mem_req", {31'd0, mem_req}, 32'd0);
        chk_eq("rst:mem_wr", {31'd0, mem_wr}, 32'd0);
        chk_eq("rst:mem_sel", {28'd0, mem_sel}, 32'd0);
        chk_eq("rst:mem_addr", mem_addr, 32'd0);
        chk_eq("rst:oks", {30'd0, inst_ok, data_ok}, 32'd0);
        chk_eq("rst:rdata", inst_rdata | data_rdata, 32'd0);
        rst = 1'b0;
        cyc();

        // Fetch alone, zero-wait memory
        inst_req = 1'b1; inst_addr = 32'h0000_0400;
        #1;
        chk_eq("f1:stall_c0", {31'd0, stall}, 32'd1);
        cyc();
        chk_eq("f1:mem_req", {31'd0, mem_req}, 32'd1);
        chk_eq("f1:mem_addr", mem_addr, 32'h0000_0400);
        chk_eq("f1:mem_sel", {28'd0, mem_sel}, 32'd0);
        chk_eq("f1:mem_wr", {31'd0, mem_wr}, 32'd0);
        chk_eq("f1:stall_c1", {31'd0, stall}, 32'd1);
        mem_addr_ok = 1'b1;
        cyc();
        chk_eq("f1:req_drop", {31'd0, mem_req}, 32'd0);
        chk_eq("f1:stall_c2", {31'd0, stall}, 32'd1);
        chk_eq("f1:no_early_ok", {31'd0, inst_ok}, 32'd0);
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h3C01_0001;
        cyc();
        mem_data_ok = 1'b0; mem_rdata = '0;
        chk_eq("f1:inst_ok", {31'd0, inst_ok}, 32'd1);
        chk_eq("f1:inst_rdata", inst_rdata, 32'h3C01_0001);
        chk_eq("f1:stall_c3", {31'd0, stall}, 32'd0);
        chk_eq("f1:data_ok", {31'd0, data_ok}, 32'd0);
        inst_req = 1'b0;
        cyc();
        chk_eq("f1:ok_one_cycle", {31'd0, inst_ok}, 32'd0);
        chk_eq("f1:rdata_hold", inst_rdata, 32'h3C01_0001);

        // Simultaneous fetch and load: data first, then fetch
        inst_req = 1'b1; inst_addr = 32'h0000_0300;
        data_req = 1'b1; data_wr = 1'b0; data_sel = 4'b1111; data_addr = 32'h0000_0100;
        do_xact("sim_d", 1'b1, 32'h0000_0100, 1'b0, 4'b0000, 32'h0, 0, 1'b0, 32'h1111_2222, lat);
        chk_eq("sim:lat_d", lat, 32'd3);
        chk_eq("sim:inst_rdata_hold", inst_rdata, 32'h3C01_0001);
        chk_eq("sim:stall_inst_wait", {31'd0, stall}, 32'd1);
        data_req = 1'b0;
        do_xact("sim_i", 1'b0, 32'h0000_0300, 1'b0, 4'b0000, 32'h0, 0, 1'b0, 32'h2222_3333, lat);
        chk_eq("sim:data_rdata_hold", data_rdata, 32'h1111_2222);
        inst_req = 1'b0;
        cyc();

        // Store with address acceptance delayed by two cycles
        data_req = 1'b1; data_wr = 1'b1; data_sel = 4'b0011;
        data_addr = 32'h0000_0200; data_wdata = 32'hDEAD_BEEF;
        do_xact("st", 1'b1, 32'h0000_0200, 1'b1, 4'b0011, 32'hDEAD_BEEF, 2, 1'b0, 32'hBAD0_BAD0, lat);
        chk_eq("st:lat", lat, 32'd5);
        chk_eq("st:rdata_kept", data_rdata, 32'h1111_2222);
        data_req = 1'b0; data_wr = 1'b0;
        cyc();
        chk_eq("st:ok_once", {31'd0, data_ok}, 32'd0);

        // Starvation guard: fetch held, five data loads -> D,D,D,D,I,D
        exp_sides = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        dcnt = 0;
        inst_req = 1'b1; inst_addr = 32'h0000_1000;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_2000;
        for (int k = 0; k < 6; k++) begin
            exp_a = exp_sides[k] ? (32'h0000_2000 + 32'(4 * dcnt)) : 32'h0000_1000;
            do_xact($sformatf("run%0d", k), exp_sides[k], exp_a, 1'b0, 4'b0000, 32'h0,
                    0, 1'b1, 32'hA000_0000 + 32'(k), lat);
            if (exp_sides[k]) begin
                dcnt++;
                if (dcnt == 5) data_req = 1'b0;
                else data_addr = 32'h0000_2000 + 32'(4 * dcnt);
            end else begin
                inst_req = 1'b0;
            end
        end
        cyc();

        // Address and data accepted in the same cycle
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0500;
        do_xact("same", 1'b1, 32'h0000_0500, 1'b0, 4'b0000, 32'h0, 0, 1'b1, 32'h5555_AAAA, lat);
        chk_eq("same:lat", lat, 32'd2);
        data_req = 1'b0;
        cyc();

        // Reset while waiting for read data
        inst_req = 1'b1; inst_addr = 32'h0000_0600;
        cyc();
        chk_eq("rstm:granted", {31'd0, mem_req}, 32'd1);
        mem_addr_ok = 1'b1;
        cyc();
        mem_addr_ok = 1'b0;
        rst = 1'b1; inst_req = 1'b0;
        cyc();
        rst = 1'b0;
        chk_eq("rstm:mem_req", {31'd0, mem_req}, 32'd0);
        chk_eq("rstm:mem_addr", mem_addr, 32'd0);
        chk_eq("rstm:inst_rdata", inst_rdata, 32'd0);
        chk_eq("rstm:data_rdata", data_rdata, 32'd0);
        chk_eq("rstm:oks", {30'd0, inst_ok, data_ok}, 32'd0);
        cyc();
        chk_eq("rstm:no_ok", {30'd0, inst_ok, data_ok}, 32'd0);
        chk_eq("rstm:idle", {31'd0, mem_req}, 32'd0);
        inst_req = 1'b1; inst_addr = 32'h0000_0700;
        do_xact("rstm_fresh", 1'b0, 32'h0000_0700, 1'b0, 4'b0000, 32'h0, 0, 1'b0, 32'hCAFE_F00D, lat);
        chk_eq("rstm:fresh_lat", lat, 32'd3);
        inst_req = 1'b0;
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "bench timeout");
    end

endmodule
